coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning consecutive synchronized samples needed to qualify a sensor level (legal range 2..255).
REQ-002 The block SHALL have parameter STUCK_CYCLES, default 1000, meaning consecutive cycles a sensor may stay high after a coin before fault (legal range 16..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sens_half, input, 1 bit: raw asynchronous 0.5-yuan slot sensor, high while a coin is present.
REQ-006 The block SHALL have port sens_one, input, 1 bit: raw asynchronous 1-yuan slot sensor, high while a coin is present.
REQ-007 The block SHALL have port inhibit, input, 1 bit: while high, qualified coins are rejected rather than credited.
REQ-008 The block SHALL have port coin, output, 2 bits: one-cycle coin code to the vending FSM (00 none, 01 0.5 yuan, 10 1 yuan; 11 never driven).
REQ-009 The block SHALL have port reject, output, 1 bit: one-cycle pulse that opens the return gate.
REQ-010 The block SHALL have port fault, output, 1 bit: sticky stuck-sensor indication.

Function
REQ-011 Each sensor SHALL pass through a two-flop synchronizer; all other logic SHALL use only synchronized values (s_half, s_one).
REQ-012 All outputs SHALL be registered; coin and reject SHALL be high for exactly one cycle per event, and coin and reject SHALL never be high in the same cycle.
REQ-013 The FSM SHALL have states IDLE, DEBOUNCE, EMIT, JAM, RELEASE.
REQ-014 IDLE: exactly one of s_half/s_one high -> DEBOUNCE, latch the coin type, sample count = 1; both high -> JAM; neither high -> stay.
REQ-015 DEBOUNCE: latched sensor high and other low -> increment count, and go to EMIT on the sample that makes count equal DEB_CYCLES; latched sensor low -> IDLE with no output; other sensor high -> JAM.
REQ-016 EMIT, one cycle: with inhibit low, drive coin with the latched code; with inhibit high, drive coin=00 and reject=1. The next state SHALL be RELEASE. inhibit SHALL be sampled only in EMIT.
REQ-017 Latency: with a clean raw pulse, coin SHALL be high in the cycle following rising edge DEB_CYCLES+2, counting edge 1 as the first edge that samples the raw sensor high.
REQ-018 JAM, one cycle: drive reject=1, coin=00, then go to RELEASE.
REQ-019 RELEASE: go to IDLE only after both synchronized sensors have been low for DEB_CYCLES consecutive cycles; any high sample SHALL restart that low count.
REQ-020 In RELEASE, a stuck counter SHALL count cycles with either sensor high and reset when both are low; when it reaches STUCK_CYCLES, fault SHALL be set.
REQ-021 fault SHALL clear on the cycle the FSM re-enters IDLE; no coin SHALL be emitted while fault is high.
REQ-022 All counters SHALL saturate and never wrap.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL set state=IDLE, clear synchronizer flops and all counters, and set coin=00, reject=0, fault=0.
REQ-024 A reset asserted mid-debounce or in EMIT SHALL drop the pending coin; no coin or reject pulse SHALL occur for it.
REQ-025 After reset release, a sensor already high SHALL be treated as a new insertion through IDLE.

Configuration
REQ-026 With macro COIN_TOTAL_EN defined, the block SHALL add output total, 16 bits, holding accepted value in 0.5-yuan units: +1 per 01 emitted, +2 per 10 emitted, rejected coins not counted, saturating at 16'hFFFF, cleared by rst.
REQ-027 Without COIN_TOTAL_EN, the total port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Scenario: DEB_CYCLES=4; sens_half held high 20 cycles -> coin=01 for exactly 1 cycle after edge 6, reject=0, return to IDLE 4 cycles after the sensor falls.
REQ-029 Scenario: sens_one glitch high 3 cycles (DEB_CYCLES=4) -> no coin and no reject; FSM back in IDLE.
REQ-030 Scenario: sens_one held 10 cycles with inhibit=1 -> reject=1 for 1 cycle, coin stays 00; with COIN_TOTAL_EN, total unchanged.
REQ-031 Scenario: sens_half rises, then sens_one rises 2 cycles later -> JAM, reject=1 for 1 cycle, no coin.
REQ-032 Scenario: STUCK_CYCLES=16; sens_half held 40 cycles -> one coin=01, fault=1 at stuck count 16, fault clears on IDLE re-entry after release, no second coin.
REQ-033 Scenario: COIN_TOTAL_EN; insert half, one, one -> total=5; rst asserted mid-debounce of a fourth coin -> total=0, no coin pulse.

Source files
------------

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced two-slot coin acceptor with jam/stuck handling; COIN_TOTAL_EN adds a 16-bit accepted-value total
module coin_acceptor #(
  parameter int DEB_CYCLES   = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sens_half,
  input  logic        sens_one,
  input  logic        inhibit,
  output logic [1:0]  coin,
  output logic        reject,
  output logic        fault
`ifdef COIN_TOTAL_EN
  ,
  output logic [15:0] total
`endif
);

  localparam logic [7:0]  DEB_MAX   = 8'(DEB_CYCLES);
  localparam logic [15:0] STUCK_MAX = 16'(STUCK_CYCLES);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, EMIT, JAM, RELEASE} state_t;

  state_t      state, state_d;
  logic        half_meta, s_half, one_meta, s_one;
  logic        is_one, is_one_d;
  logic [7:0]  cnt, cnt_d, cnt_inc;
  logic [15:0] stuck, stuck_d, stuck_inc;
  logic [1:0]  coin_d;
  logic        reject_d, fault_d;
  logic        own, other;

  assign own       = is_one ? s_one : s_half;
  assign other     = is_one ? s_half : s_one;
  assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign stuck_inc = (stuck == 16'hFFFF) ? stuck : stuck + 16'd1;

  // two-flop synchronizers for the raw slot sensors
  always_ff @(posedge clk) begin
    if (rst) begin
      half_meta <= 1'b0;
      s_half    <= 1'b0;
      one_meta  <= 1'b0;
      s_one     <= 1'b0;
    end else begin
      half_meta <= sens_half;
      s_half    <= half_meta;
      one_meta  <= sens_one;
      s_one     <= one_meta;
    end
  end

  // state register, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      is_one <= 1'b0;
      cnt    <= 8'd0;
      stuck  <= 16'd0;
      coin   <= 2'b00;
      reject <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_d;
      is_one <= is_one_d;
      cnt    <= cnt_d;
      stuck  <= stuck_d;
      coin   <= coin_d;
      reject <= reject_d;
      fault  <= fault_d;
    end
  end

  // next-state decode; coin/reject are registered on the edge that enters
  // EMIT or JAM so the pulse occupies exactly that one-cycle state
  always_comb begin
    state_d  = state;
    is_one_d = is_one;
    cnt_d    = cnt;
    stuck_d  = stuck;
    coin_d   = 2'b00;
    reject_d = 1'b0;
    fault_d  = fault;
    case (state)
      IDLE: begin
        stuck_d = 16'd0;
        fault_d = 1'b0;
        if (s_half && s_one) begin
          state_d  = JAM;
          reject_d = 1'b1;
        end else if (s_half || s_one) begin
          state_d  = DEBOUNCE;
          is_one_d = s_one;
          cnt_d    = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (other) begin
          state_d  = JAM;
          reject_d = 1'b1;
        end else if (!own) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            state_d = EMIT;
            // inhibit is only consulted at this single decision point
            if (!inhibit && !fault) begin
              coin_d = is_one ? 2'b10 : 2'b01;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      end
      EMIT, JAM: begin
        state_d = RELEASE;
        cnt_d   = 8'd0;
        stuck_d = 16'd0;
      end
      RELEASE: begin
        if (s_half || s_one) begin
          cnt_d   = 8'd0;
          stuck_d = stuck_inc;
          if (stuck_inc >= STUCK_MAX) begin
            fault_d = 1'b1;
          end
        end else begin
          stuck_d = 16'd0;
          cnt_d   = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            state_d = IDLE;
            fault_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef COIN_TOTAL_EN
  // saturating running total of credited value in half-yuan units
  always_ff @(posedge clk) begin
    if (rst) begin
      total <= 16'd0;
    end else if (coin_d == 2'b01) begin
      total <= (total == 16'hFFFF) ? total : total + 16'd1;
    end else if (coin_d == 2'b10) begin
      total <= (total >= 16'hFFFE) ? 16'hFFFF : total + 16'd2;
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor; total checks compiled only with COIN_TOTAL_EN
module tb_coin_acceptor;

  localparam int DEB   = 4;
  localparam int STUCK = 16;

  logic        clk = 1'b0;
  logic        rst, sens_half, sens_one, inhibit;
  logic [1:0]  coin;
  logic        reject, fault;
`ifdef COIN_TOTAL_EN
  logic [15:0] total;
`endif

  typedef struct {
    int         cyc;
    logic [2:0] ev;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   c;
  logic mon_en = 1'b0;

  coin_acceptor #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .sens_half (sens_half),
    .sens_one  (sens_one),
    .inhibit   (inhibit),
    .coin      (coin),
    .reject    (reject),
    .fault     (fault)
`ifdef COIN_TOTAL_EN
    ,
    .total     (total)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at, input logic [2:0] ev);
    exp_t t;
    t.cyc = at;
    t.ev  = ev;
    sb.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // every pulse on coin/reject is matched against the next scoreboard entry
  always @(negedge clk) begin
    if (mon_en && (coin !== 2'b00 || reject !== 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {29'd0, coin, reject}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_code", {29'd0, coin, reject}, {29'd0, e.ev});
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; sens_half = 1'b0; sens_one = 1'b0; inhibit = 1'b0;
    tick(3);
    check("reset_coin", {30'd0, coin}, 32'd0);
    check("reset_reject", {31'd0, reject}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
`ifdef COIN_TOTAL_EN
    check("reset_total", {16'd0, total}, 32'd0);
`endif
    rst = 1'b0;
    mon_en = 1'b1;

    // half held 20 cycles; a one-yuan coin seen on the first IDLE sample proves exact release time
    c = cyc; sens_half = 1'b1; push(c + 6, 3'b010);
    tick(20); sens_half = 1'b0;
    tick(4); sens_one = 1'b1; push(c + 30, 3'b100);
    tick(10); sens_one = 1'b0;
    tick(20);
    check("a_drained", sb.size(), 32'd0);
`ifdef COIN_TOTAL_EN
    check("a_total", {16'd0, total}, 32'd3);
`endif

    // three-cycle glitch is ignored, then a real half coin is accepted
    sens_one = 1'b1; tick(3); sens_one = 1'b0;
    tick(15);
    c = cyc; sens_half = 1'b1; push(c + 6, 3'b010);
    tick(8); sens_half = 1'b0;
    tick(15);
    check("b_drained", sb.size(), 32'd0);

    // inhibited coin is rejected
    inhibit = 1'b1;
    c = cyc; sens_one = 1'b1; push(c + 6, 3'b001);
    tick(10); sens_one = 1'b0;
    tick(15);
    inhibit = 1'b0;
    check("c_drained", sb.size(), 32'd0);
`ifdef COIN_TOTAL_EN
    check("c_total", {16'd0, total}, 32'd4);
`endif

    // second sensor during debounce jams
    c = cyc; sens_half = 1'b1;
    tick(2); sens_one = 1'b1; push(c + 5, 3'b001);
    tick(6); sens_half = 1'b0; sens_one = 1'b0;
    tick(15);
    check("d_drained", sb.size(), 32'd0);

    // stuck sensor raises fault, cleared on IDLE re-entry
    c = cyc; sens_half = 1'b1; push(c + 6, 3'b010);
    tick(22);
    check("e_fault_before", {31'd0, fault}, 32'd0);
    tick(1);
    check("e_fault_set", {31'd0, fault}, 32'd1);
    tick(17); sens_half = 1'b0;
    tick(5);
    check("e_fault_held", {31'd0, fault}, 32'd1);
    tick(1);
    check("e_fault_clear", {31'd0, fault}, 32'd0);
    tick(10);
    check("e_drained", sb.size(), 32'd0);

    // reset, then half/one/one, then reset mid-debounce
    rst = 1'b1; tick(1); rst = 1'b0;
`ifdef COIN_TOTAL_EN
    check("f_total_reset", {16'd0, total}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      if (i == 0) begin sens_half = 1'b1; push(c + 6, 3'b010); end
      else begin sens_one = 1'b1; push(c + 6, 3'b100); end
      tick(8); sens_half = 1'b0; sens_one = 1'b0;
      tick(15);
    end
    check("f_drained", sb.size(), 32'd0);
`ifdef COIN_TOTAL_EN
    check("f_total_five", {16'd0, total}, 32'd5);
`endif
    sens_half = 1'b1; tick(4);
    rst = 1'b1; sens_half = 1'b0; tick(1); rst = 1'b0;
`ifdef COIN_TOTAL_EN
    check("f_total_cleared", {16'd0, total}, 32'd0);
`endif
    tick(15);
    check("f_no_coin", sb.size(), 32'd0);

    // sensor held through reset is a fresh insertion after release
    sens_one = 1'b1; tick(4);
    rst = 1'b1; tick(1); rst = 1'b0;
    c = cyc; push(c + 6, 3'b100);
    tick(10); sens_one = 1'b0;
    tick(15);
    check("g_drained", sb.size(), 32'd0);
`ifdef COIN_TOTAL_EN
    check("g_total", {16'd0, total}, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
